// File: rtl/vagas_monitor.sv
// Multi-spot parking occupancy monitor: synchronised, debounced presence sensors with per-spot
// LED drive, occupy/release event pulses and registered occupied/free totals.
module vagas_monitor #(
  parameter int unsigned N_VAGAS      = 4,
  parameter int unsigned DEBOUNCE_MAX = 6,
  localparam int unsigned CW          = $clog2(N_VAGAS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_VAGAS-1:0] sensor,
  input  logic [N_VAGAS-1:0] bloqueio,
  output logic [N_VAGAS-1:0] led_green,
  output logic [N_VAGAS-1:0] led_red,
  output logic [N_VAGAS-1:0] evt_ocupou,
  output logic [N_VAGAS-1:0] evt_liberou,
  output logic [CW-1:0]      ocupadas,
  output logic [CW-1:0]      livres,
  output logic               lotado,
  output logic               vazio
);

  localparam int unsigned CNTW = $clog2(DEBOUNCE_MAX + 1);

  localparam logic [CNTW-1:0] CntMax = CNTW'(DEBOUNCE_MAX);
  localparam logic [CNTW-1:0] CntOne = CNTW'(1);
  localparam logic [CW-1:0]   CwOne  = CW'(1);
  localparam logic [CW-1:0]   CwN    = CW'(N_VAGAS);

  localparam logic LIVRE   = 1'b0;
  localparam logic OCUPADA = 1'b1;

  logic [N_VAGAS-1:0] sync1_q, sync1_d;
  logic [N_VAGAS-1:0] sync2_q, sync2_d;
  logic [N_VAGAS-1:0] state_q, state_d;
  logic [N_VAGAS-1:0] state_dly_q, state_dly_d;
  logic [N_VAGAS-1:0] evt_ocupou_q, evt_ocupou_d;
  logic [N_VAGAS-1:0] evt_liberou_q, evt_liberou_d;
  logic [CNTW-1:0]    cnt_q [N_VAGAS];
  logic [CNTW-1:0]    cnt_d [N_VAGAS];
  logic [CW-1:0]      ocupadas_q, ocupadas_d;
  logic [CW-1:0]      livres_q, livres_d;
  logic               lotado_q, lotado_d;
  logic               vazio_q, vazio_d;
  logic [CW-1:0]      blk_cnt;

  always_comb begin
    sync1_d = sensor;
    sync2_d = sync1_q;
  end

  // Saturating integrator; state only flips at the rails, giving hysteresis in between.
  always_comb begin
    for (int i = 0; i < N_VAGAS; i++) begin
      cnt_d[i]   = cnt_q[i];
      state_d[i] = state_q[i];
      if (sync2_q[i] && (cnt_q[i] != CntMax)) begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end else if (!sync2_q[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CntOne;
      end
      if ((state_q[i] == LIVRE) && (cnt_d[i] == CntMax)) begin
        state_d[i] = OCUPADA;
      end else if ((state_q[i] == OCUPADA) && (cnt_d[i] == '0)) begin
        state_d[i] = LIVRE;
      end
    end
  end

  // Events fire one edge after the state change, hence the delayed copy of state.
  always_comb begin
    state_dly_d   = state_q;
    evt_ocupou_d  = state_q & ~state_dly_q;
    evt_liberou_d = ~state_q & state_dly_q;
  end

  always_comb begin
    ocupadas_d = '0;
    blk_cnt    = '0;
    for (int i = 0; i < N_VAGAS; i++) begin
      if ((state_q[i] == OCUPADA) && !bloqueio[i]) begin
        ocupadas_d = ocupadas_d + CwOne;
      end
      if (bloqueio[i]) begin
        blk_cnt = blk_cnt + CwOne;
      end
    end
    livres_d = CwN - ocupadas_d - blk_cnt;
    lotado_d = (livres_d == '0);
    vazio_d  = (ocupadas_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      state_q       <= {N_VAGAS{LIVRE}};
      state_dly_q   <= {N_VAGAS{LIVRE}};
      evt_ocupou_q  <= '0;
      evt_liberou_q <= '0;
      for (int i = 0; i < N_VAGAS; i++) begin
        cnt_q[i] <= '0;
      end
      ocupadas_q    <= '0;
      livres_q      <= CwN;
      lotado_q      <= 1'b0;
      vazio_q       <= 1'b1;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      state_q       <= state_d;
      state_dly_q   <= state_dly_d;
      evt_ocupou_q  <= evt_ocupou_d;
      evt_liberou_q <= evt_liberou_d;
      for (int i = 0; i < N_VAGAS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ocupadas_q    <= ocupadas_d;
      livres_q      <= livres_d;
      lotado_q      <= lotado_d;
      vazio_q       <= vazio_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N_VAGAS; i++) begin
      led_red[i] = (state_q[i] == OCUPADA) || bloqueio[i];
    end
    led_green   = ~led_red;
    evt_ocupou  = evt_ocupou_q;
    evt_liberou = evt_liberou_q;
    ocupadas    = ocupadas_q;
    livres      = livres_q;
    lotado      = lotado_q;
    vazio       = vazio_q;
  end

endmodule
